// File: rtl/sdram_emu_pkg.sv
// Shared types and constants for the SDRAM device emulator.
package sdram_emu_pkg;

    // Command encodings as {nRAS, nCAS, nWE}
    typedef enum logic [2:0] {
        CMD_LOAD_MODE    = 3'b000,
        CMD_AUTO_REFRESH = 3'b001,
        CMD_PRECHARGE    = 3'b010,
        CMD_ACTIVE       = 3'b011,
        CMD_WRITE        = 3'b100,
        CMD_READ         = 3'b101,
        CMD_NOP          = 3'b111
    } cmd_e;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_e;

    // Per-read sideband carried alongside the registered memory read
    typedef struct packed {
        logic valid;
        logic zero;
        logic mask_lo;
        logic mask_hi;
    } rd_meta_t;

    localparam logic [2:0] CL_MIN   = 3'd2;
    localparam logic [2:0] CL_MAX   = 3'd3;
    localparam logic [2:0] CL_RESET = 3'd2;

    function automatic logic cl_legal(input logic [2:0] cl);
        return (cl >= CL_MIN) && (cl <= CL_MAX);
    endfunction

endpackage

// File: rtl/sdram_emu_mem.sv
// Single-port 16-bit backing store with byte enables and a registered read.
// Contents are deliberately not reset so data survives a controller reset.
module sdram_emu_mem #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [1:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] store [0:(1 << AW) - 1];

    // Byte-masked write, or capture of the addressed word for a read
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                if (be[0]) store[addr][7:0]  <= wdata[7:0];
                if (be[1]) store[addr][15:8] <= wdata[15:8];
            end else begin
                rdata <= store[addr];
            end
        end
    end

endmodule

// File: rtl/sdram_emu.sv
// Cycle-level SDRAM device model: command decode, bank tracking, error
// flags, refresh counting and a CAS-latency read pipeline.
module sdram_emu
    import sdram_emu_pkg::*;
#(
    parameter int MEM_AW = 16,
    parameter int TRCD   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [12:0] SDRAM_A,
    input  logic [1:0]  SDRAM_BA,
    input  logic        SDRAM_nCS,
    input  logic        SDRAM_nRAS,
    input  logic        SDRAM_nCAS,
    input  logic        SDRAM_nWE,
    input  logic        SDRAM_CKE,
    input  logic        SDRAM_DQML,
    input  logic        SDRAM_DQMH,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        mode_valid,
    output logic        err_proto,
    output logic        err_timing,
    output logic [15:0] refresh_cnt
);

    cmd_e              cmd;
    bank_state_e       bank_state [4];
    logic [12:0]       bank_row   [4];
    logic [7:0]        bank_age   [4];
    logic [2:0]        cl;
    logic              any_active;
    logic              access_ok;
    logic              too_early;
    logic              mem_en;
    logic              mem_we;
    logic [1:0]        mem_be;
    logic [MEM_AW-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    rd_meta_t          p0;
    logic              s1_valid, s2_valid;
    logic [15:0]       s1_data, s2_data;

    // Decode pins into a command; deselected or clock-disabled cycles are NOPs
    always_comb begin
        cmd = CMD_NOP;
        if (!SDRAM_nCS && SDRAM_CKE) begin
            case ({SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE})
                3'b000:  cmd = CMD_LOAD_MODE;
                3'b001:  cmd = CMD_AUTO_REFRESH;
                3'b010:  cmd = CMD_PRECHARGE;
                3'b011:  cmd = CMD_ACTIVE;
                3'b100:  cmd = CMD_WRITE;
                3'b101:  cmd = CMD_READ;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    // Access legality, timing check and memory port controls
    always_comb begin
        any_active = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bank_state[i] == BANK_ACTIVE) any_active = 1'b1;
        end
        access_ok = (bank_state[SDRAM_BA] == BANK_ACTIVE) && mode_valid;
        too_early = (bank_state[SDRAM_BA] == BANK_ACTIVE) &&
                    (bank_age[SDRAM_BA] < 8'(TRCD));
        mem_en    = (cmd == CMD_READ) || ((cmd == CMD_WRITE) && access_ok);
        mem_we    = (cmd == CMD_WRITE);
        mem_be    = {~SDRAM_DQMH, ~SDRAM_DQML};
        mem_addr  = MEM_AW'({SDRAM_BA, bank_row[SDRAM_BA], SDRAM_A[8:0]});
    end

    // Bank state, mode register, error flags and refresh counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                bank_state[i] <= BANK_IDLE;
                bank_row[i]   <= '0;
                bank_age[i]   <= '0;
            end
            cl          <= CL_RESET;
            mode_valid  <= 1'b0;
            err_proto   <= 1'b0;
            err_timing  <= 1'b0;
            refresh_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (bank_age[i] < 8'(TRCD)) bank_age[i] <= bank_age[i] + 8'd1;
            end
            case (cmd)
                CMD_ACTIVE: begin
                    if (bank_state[SDRAM_BA] == BANK_ACTIVE) err_proto <= 1'b1;
                    bank_state[SDRAM_BA] <= BANK_ACTIVE;
                    bank_row[SDRAM_BA]   <= SDRAM_A;
                    // age counts edges elapsed since ACTIVE, as seen by the next command
                    bank_age[SDRAM_BA]   <= 8'd1;
                end
                CMD_PRECHARGE: begin
                    if (SDRAM_A[10]) begin
                        for (int unsigned i = 0; i < 4; i++) bank_state[i] <= BANK_IDLE;
                    end else begin
                        bank_state[SDRAM_BA] <= BANK_IDLE;
                    end
                end
                CMD_LOAD_MODE: begin
                    cl <= SDRAM_A[6:4];
                    if (cl_legal(SDRAM_A[6:4])) begin
                        mode_valid <= 1'b1;
                    end else begin
                        mode_valid <= 1'b0;
                        err_proto  <= 1'b1;
                    end
                end
                CMD_AUTO_REFRESH: begin
                    refresh_cnt <= refresh_cnt + 16'd1;
                    if (any_active) err_proto <= 1'b1;
                end
                CMD_READ, CMD_WRITE: begin
                    if (too_early) err_timing <= 1'b1;
                    if (!access_ok) begin
                        err_proto <= 1'b1;
                    end else if (SDRAM_A[10]) begin
                        bank_state[SDRAM_BA] <= BANK_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    sdram_emu_mem #(
        .AW(MEM_AW)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .be    (mem_be),
        .addr  (mem_addr),
        .wdata (dq_in),
        .rdata (mem_rdata)
    );

    // Read pipeline: p0 travels beside the memory read, s1/s2 are the CL-1
    // trailing stages, and the output register taps s1 or s2 by latched CL
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p0       <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            dq_oe    <= 1'b0;
            dq_out   <= '0;
        end else begin
            p0.valid   <= (cmd == CMD_READ);
            p0.zero    <= !access_ok;
            p0.mask_lo <= SDRAM_DQML;
            p0.mask_hi <= SDRAM_DQMH;
            s1_valid   <= p0.valid;
            s1_data    <= '0;
            if (p0.valid && !p0.zero) begin
                s1_data[7:0]  <= p0.mask_lo ? 8'h00 : mem_rdata[7:0];
                s1_data[15:8] <= p0.mask_hi ? 8'h00 : mem_rdata[15:8];
            end
            s2_valid <= s1_valid;
            s2_data  <= s1_data;
            if (cl == CL_MAX) begin
                dq_oe  <= s2_valid;
                dq_out <= s2_data;
            end else begin
                dq_oe  <= s1_valid;
                dq_out <= s1_data;
            end
        end
    end

endmodule

// File: tb/tb_sdram_emu.sv
// Directed bench for sdram_emu: stimulus pushes expected read returns into a
// queue, a negedge monitor pops and compares on every dq_oe pulse.
module tb_sdram_emu;

    localparam logic [2:0] C_LMR = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_NOP = 3'b111;

    typedef struct {
        logic [15:0] data;
        int          slot;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] a;
    logic [1:0]  ba;
    logic        ncs, nras, ncas, nwe, cke, dqml, dqmh;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe, mode_valid, err_proto, err_timing;
    logic [15:0] refresh_cnt;

    int   checks = 0;
    int   errors = 0;
    int   edge_no = 0;
    bit   armed = 1'b0;
    exp_t expq[$];

    sdram_emu #(
        .MEM_AW(16),
        .TRCD  (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .SDRAM_A     (a),
        .SDRAM_BA    (ba),
        .SDRAM_nCS   (ncs),
        .SDRAM_nRAS  (nras),
        .SDRAM_nCAS  (ncas),
        .SDRAM_nWE   (nwe),
        .SDRAM_CKE   (cke),
        .SDRAM_DQML  (dqml),
        .SDRAM_DQMH  (dqmh),
        .dq_in       (dq_in),
        .dq_out      (dq_out),
        .dq_oe       (dq_oe),
        .mode_valid  (mode_valid),
        .err_proto   (err_proto),
        .err_timing  (err_timing),
        .refresh_cnt (refresh_cnt)
    );

    always #5 clk = ~clk;

    // Edge counter used to time-stamp expected read slots
    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] rcw, input logic [1:0] b, input logic [12:0] addr,
                         input logic [15:0] d, input logic ml = 1'b0, input logic mh = 1'b0,
                         input logic cs_n = 1'b0, input logic ck = 1'b1);
        @(negedge clk);
        ncs = cs_n;
        cke = ck;
        {nras, ncas, nwe} = rcw;
        ba = b;
        a = addr;
        dq_in = d;
        dqml = ml;
        dqmh = mh;
    endtask

    task automatic nop(input int n);
        repeat (n) drive(C_NOP, 2'd0, 13'h0, 16'h0);
    endtask

    task automatic rd(input logic [1:0] b, input logic [12:0] addr, input logic [15:0] exp,
                      input int cl, input string nm, input logic ml = 1'b0, input logic mh = 1'b0);
        drive(C_RD, b, addr, 16'h0, ml, mh);
        expq.push_back('{data: exp, slot: edge_no + 1 + cl, name: nm});
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset_n = 1'b0;
        ncs = 1'b1;
        {nras, ncas, nwe} = C_NOP;
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: every dq_oe pulse must match the oldest pending read
    always @(negedge clk) begin
        if (armed && dq_oe) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dq_oe: got dq_oe=1 data 0x%04h at edge %0d, required no pulse",
                         dq_out, edge_no);
            end else begin
                exp_t e;
                e = expq.pop_front();
                checks++;
                if (dq_out !== e.data) begin
                    errors++;
                    $display("FAIL %s data: got 0x%04h expected 0x%04h", e.name, dq_out, e.data);
                end
                checks++;
                if (edge_no != e.slot) begin
                    errors++;
                    $display("FAIL %s slot: got edge %0d expected edge %0d", e.name, edge_no, e.slot);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        ncs = 1'b1; cke = 1'b1; {nras, ncas, nwe} = C_NOP;
        a = '0; ba = '0; dqml = 1'b0; dqmh = 1'b0; dq_in = '0;

        do_reset(2);
        armed = 1'b1;
        check("rst_mode_valid", mode_valid, 16'h0);
        check("rst_err_proto", err_proto, 16'h0);
        check("rst_err_timing", err_timing, 16'h0);
        check("rst_refresh_cnt", refresh_cnt, 16'h0);
        check("rst_dq_oe", dq_oe, 16'h0);
        check("rst_dq_out", dq_out, 16'h0);

        // CL=2 basic write/read
        drive(C_LMR, 2'd0, 13'h0220, 16'h0);
        nop(1);
        check("lmr_cl2_valid", mode_valid, 16'h1);
        drive(C_ACT, 2'd1, 13'h0012, 16'h0);
        nop(2);
        drive(C_WR, 2'd1, 13'h0005, 16'hBEEF);
        rd(2'd1, 13'h0005, 16'hBEEF, 2, "rd_cl2");
        nop(4);
        check("basic_err_proto", err_proto, 16'h0);
        check("basic_err_timing", err_timing, 16'h0);

        // CL=3 with read masks and masked write
        drive(C_LMR, 2'd0, 13'h0230, 16'h0);
        rd(2'd1, 13'h0005, 16'h00EF, 3, "rd_dqmh", 1'b0, 1'b1);
        nop(5);
        check("cl3_err_proto", err_proto, 16'h0);
        check("cl3_err_timing", err_timing, 16'h0);
        drive(C_WR, 2'd1, 13'h0005, 16'h1234, 1'b1, 1'b0);
        rd(2'd1, 13'h0005, 16'h12EF, 3, "rd_merge");
        nop(5);

        // Write between reads: first read keeps its captured value
        rd(2'd1, 13'h0005, 16'h12EF, 3, "rd_before_wr");
        drive(C_WR, 2'd1, 13'h0005, 16'hAAAA);
        rd(2'd1, 13'h0005, 16'hAAAA, 3, "rd_after_wr");
        nop(5);

        // Back-to-back reads overlap in the pipeline
        drive(C_WR, 2'd1, 13'h0006, 16'h5A5A);
        drive(C_WR, 2'd1, 13'h0007, 16'h0F0F);
        rd(2'd1, 13'h0005, 16'hAAAA, 3, "b2b_0");
        rd(2'd1, 13'h0006, 16'h5A5A, 3, "b2b_1");
        rd(2'd1, 13'h0007, 16'h0F0F, 3, "b2b_2");
        nop(6);
        check("b2b_err_timing", err_timing, 16'h0);

        // tRCD violation still completes
        drive(C_ACT, 2'd2, 13'h0007, 16'h0);
        nop(2);
        drive(C_WR, 2'd2, 13'h0000, 16'h7777);
        drive(C_PRE, 2'd2, 13'h0000, 16'h0);
        drive(C_ACT, 2'd2, 13'h0007, 16'h0);
        rd(2'd2, 13'h0000, 16'h7777, 3, "rd_early");
        nop(5);
        check("early_err_timing", err_timing, 16'h1);
        check("early_err_proto", err_proto, 16'h0);

        // Idle-bank read, single-bank vs all-bank precharge
        drive(C_PRE, 2'd2, 13'h0000, 16'h0);
        rd(2'd2, 13'h0000, 16'h0000, 3, "rd_idle");
        nop(5);
        check("idle_err_proto", err_proto, 16'h1);
        rd(2'd1, 13'h0005, 16'hAAAA, 3, "rd_bank1_open");
        drive(C_PRE, 2'd0, 13'h0400, 16'h0);
        rd(2'd1, 13'h0005, 16'h0000, 3, "rd_after_pre_all");
        nop(5);

        // Illegal CAS latency
        drive(C_LMR, 2'd0, 13'h0050, 16'h0);
        nop(1);
        check("bad_cl_mode_valid", mode_valid, 16'h0);

        // Reset keeps memory; refresh counting and deselect/CKE gating
        do_reset(1);
        check("rst2_err_proto", err_proto, 16'h0);
        check("rst2_err_timing", err_timing, 16'h0);
        check("rst2_mode_valid", mode_valid, 16'h0);
        repeat (3) drive(C_REF, 2'd0, 13'h0, 16'h0);
        nop(1);
        check("ref3_cnt", refresh_cnt, 16'd3);
        check("ref3_err_proto", err_proto, 16'h0);
        drive(C_REF, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(C_REF, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        nop(1);
        check("ref_gated_cnt", refresh_cnt, 16'd3);

        // Auto-precharge read, then read of the now-closed bank
        drive(C_LMR, 2'd0, 13'h0220, 16'h0);
        drive(C_ACT, 2'd1, 13'h0012, 16'h0);
        nop(2);
        rd(2'd1, 13'h0405, 16'hAAAA, 2, "rd_after_reset_ap");
        rd(2'd1, 13'h0005, 16'h0000, 2, "rd_closed");
        nop(4);
        check("ap_err_proto", err_proto, 16'h1);
        check("ap_err_timing", err_timing, 16'h0);

        // Reset between READ and its data slot suppresses the pulse
        do_reset(1);
        drive(C_LMR, 2'd0, 13'h0220, 16'h0);
        drive(C_ACT, 2'd1, 13'h0012, 16'h0);
        nop(2);
        drive(C_RD, 2'd1, 13'h0005, 16'h0);
        do_reset(1);
        repeat (4) begin
            @(negedge clk);
            check("no_oe_after_reset", dq_oe, 16'h0);
        end
        drive(C_REF, 2'd0, 13'h0, 16'h0);
        nop(1);
        check("post_rst_ref_proto", err_proto, 16'h0);
        check("post_rst_ref_cnt", refresh_cnt, 16'd1);
        drive(C_LMR, 2'd0, 13'h0220, 16'h0);
        drive(C_ACT, 2'd3, 13'h0000, 16'h0);
        drive(C_REF, 2'd0, 13'h0, 16'h0);
        nop(1);
        check("ref_active_proto", err_proto, 16'h1);
        check("ref_active_cnt", refresh_cnt, 16'd2);

        // Refresh counter wrap
        do_reset(1);
        repeat (65535) drive(C_REF, 2'd0, 13'h0, 16'h0);
        nop(1);
        check("ref_max", refresh_cnt, 16'hFFFF);
        drive(C_REF, 2'd0, 13'h0, 16'h0);
        nop(1);
        check("ref_wrap", refresh_cnt, 16'h0000);

        // Bounded drain of any outstanding reads
        for (int i = 0; i < 20 && expq.size() != 0; i++) @(negedge clk);
        while (expq.size() != 0) begin
            exp_t e;
            e = expq.pop_front();
            checks++;
            errors++;
            $display("FAIL %s missing: got no dq_oe pulse, expected data 0x%04h at edge %0d",
                     e.name, e.data, e.slot);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
